// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake. It shifts the word out
// MSB first, one bit per clock. Each bit is qualified by out_valid, and last
// marks the final bit of the frame.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit after
// the data LSB. The frame is then WIDTH+1 bits long.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [FL-1:0] shreg;
  logic [FL-1:0] shreg_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [FL-1:0] load_word;
  logic          transfer;

  // Build the full frame image captured on a transfer. With parity enabled,
  // the parity bit sits in the LSB, so it leaves the shifter last.
  always_comb begin
`ifdef PISO_TX_PARITY_EN
    load_word = {data_in, ^data_in};
`else
    load_word = data_in;
`endif
  end

  // Decode outputs from the registered state and compute the next state.
  // A reload on the last bit keeps the stream gap-free.
  always_comb begin
    out_valid  = 1'b0;
    out        = 1'b0;
    last       = 1'b0;
    load_ready = 1'b0;
    state_next = state;
    shreg_next = shreg;
    count_next = count;

    case (state)
      IDLE: begin
        load_ready = reset_;
      end
      SHIFT: begin
        out_valid  = 1'b1;
        out        = shreg[FL-1];
        last       = (count == CW'(FL - 1));
        load_ready = reset_ & last;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    transfer = load_valid & load_ready;

    if (transfer) begin
      state_next = SHIFT;
      shreg_next = load_word;
      count_next = '0;
    end else if (state == SHIFT) begin
      shreg_next = shreg << 1;
      if (last) begin
        state_next = IDLE;
        count_next = '0;
      end else begin
        count_next = count + 1'b1;
      end
    end
  end

  // Register the state. A low reset_ discards any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed bench for piso_tx.
// The reference model keeps the bits still to be sent in a queue.
// Honours PISO_TX_PARITY_EN when the design is built with it.
module tb_piso_tx;

  localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk;
  logic             reset_;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             out;
  logic             out_valid;
  logic             last;
  logic [3:0]       obs;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic q[$];
  logic accepted;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .data_in   (data_in),
    .out       (out),
    .out_valid (out_valid),
    .last      (last)
  );

  assign obs = {out_valid, out, last, load_ready};

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {out_valid, out, last, load_ready}, taken from the bits still pending
  function automatic logic [3:0] model_exp();
    logic ov, o, l, lr;
    ov = (q.size() > 0);
    o  = ov ? q[0] : 1'b0;
    l  = (q.size() == 1);
    lr = reset_ && (q.size() <= 1);
    return {ov, o, l, lr};
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    load_valid = v;
    data_in    = d;
    reset_     = r;
  endtask

  // Advance one clock and update the model with the inputs that were applied
  task automatic advance();
    logic b;
    @(posedge clk);
    accepted = 1'b0;
    if (!reset_) begin
      q.delete();
    end else begin
      accepted = load_valid && (q.size() <= 1);
      if (q.size() > 0) b = q.pop_front();
      if (accepted) begin
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(data_in[i]);
`ifdef PISO_TX_PARITY_EN
        q.push_back(^data_in);
`endif
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    drive(1'b1, 8'hFF, 1'b0);
    advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc %0d: got %b required %b", cyc, obs, 4'b0000);
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    exp = model_exp();
    checks++;
    if (obs !== exp || exp !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_release cyc %0d: got %b required %b", cyc, obs, 4'b0001);
    end
    advance();
  endtask

  task automatic test_single_frame();
    logic [3:0] exp;
    logic [7:0] word;
    word = 8'hA5;
    drive(1'b1, word, 1'b1);
    for (int i = 0; i < FL + 3; i++) begin
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL single_frame cyc %0d: got %b required %b", cyc, obs, exp);
      end
      if (i >= 1 && i <= WIDTH) begin
        checks++;
        if (out !== word[WIDTH - i]) begin
          errors++;
          $display("[TB] FAIL a5_bit%0d: got %b required %b", i, out, word[WIDTH - i]);
        end
      end
      advance();
      if (i == 0) drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int stage;
    stage = 0;
    drive(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 2 * FL + 4; i++) begin
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc %0d: got %b required %b", cyc, obs, exp);
      end
      advance();
      if (accepted) stage++;
      if (stage == 1) drive(1'b1, 8'h3C, 1'b1);
      else drive(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (stage !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_accepts: got %0d required %0d", stage, 2);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] exp;
    drive(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 2 * FL + 10; i++) begin
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_midframe cyc %0d: got %b required %b", cyc, obs, exp);
      end
      advance();
      if (i == 3 || i == 4) drive(1'b1, 8'hFF, 1'b0);
      else if (i == 6) drive(1'b1, 8'h01, 1'b1);
      else drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_ignored_load();
    logic [3:0] exp;
    drive(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < FL + 6; i++) begin
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL ignored_load cyc %0d: got %b required %b", cyc, obs, exp);
      end
      advance();
      if (i == 2) drive(1'b1, 8'h00, 1'b1);
      else drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0), WIDTH'($urandom), ($urandom_range(0, 60) != 0));
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: got %b required %b", cyc, obs, exp);
      end
      advance();
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_midframe();
    test_ignored_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
